// File: rtl/earom_pkg.sv
// Shared definitions for the EAROM emulation: CPU mode encodings and controller states.
package earom_pkg;

  localparam logic [1:0] CMD_WRITE = 2'b00;
  localparam logic [1:0] CMD_ERASE = 2'b01;
  localparam logic [1:0] CMD_READ  = 2'b10;
  localparam logic [1:0] CMD_STBY  = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    PROG,
    HOST
  } state_t;

endpackage

// File: rtl/earom_mem.sv
// Single-port synchronous RAM (read-first) backing the EAROM contents; no reset.
module earom_mem #(
  parameter int AW = 6,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic          we,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] q
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    q <= mem[addr];
  end

endmodule

// File: rtl/earom_ctrl.sv
// EAROM emulation controller: CPU command decode, timed program/erase, host load/save port.
// Optional EAROM_OR_WRITE_EN: CPU WRITE ORs data into the cell instead of overwriting it.
module earom_ctrl
  import earom_pkg::*;
#(
  parameter int AW          = 6,
  parameter int DW          = 8,
  parameter int PROG_CYCLES = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cs,
  input  logic          c1,
  input  logic          c2,
  input  logic          cmd_stb,
  input  logic [AW-1:0] a,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          busy,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_din,
  output logic [DW-1:0] host_dout,
  output logic          host_ack,
  output logic          dirty,
  input  logic          dirty_clr
);

  localparam int CW = $clog2(PROG_CYCLES) + 1;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_din;
  logic          lat_erase;
  logic          rd_p1;
  logic [DW-1:0] dout_q, host_q;

  logic [1:0]    mode;
  logic          cpu_go, start_prog, rd_go, prog_last;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata, ram_q;

  function automatic logic [DW-1:0] prog_value(input logic erase,
                                               input logic [DW-1:0] wr,
                                               input logic [DW-1:0] old);
    if (erase) return '0;
`ifdef EAROM_OR_WRITE_EN
    return old | wr;
`else
    return wr;
`endif
  endfunction

  earom_mem #(.AW(AW), .DW(DW)) u_mem (
    .clk   (clk),
    .addr  (ram_addr),
    .we    (ram_we),
    .wdata (ram_wdata),
    .q     (ram_q)
  );

  assign mode      = {c1, c2};
  assign cpu_go    = (state == IDLE) && cmd_stb && cs;
  assign prog_last = (state == PROG) && (cnt == '0);

  // The RAM address follows the CPU bus in IDLE, so by the last PROG clock ram_q
  // always holds the old contents of the target cell for the OR-write merge.
  always_comb begin
    state_nxt  = state;
    ram_addr   = a;
    ram_we     = 1'b0;
    ram_wdata  = din;
    start_prog = 1'b0;
    rd_go      = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_go && (mode == CMD_WRITE || mode == CMD_ERASE)) begin
          start_prog = 1'b1;
          state_nxt  = PROG;
        end else if (cpu_go && mode == CMD_READ) begin
          rd_go = 1'b1;
        end else if (host_req) begin
          state_nxt = HOST;
        end
      end
      PROG: begin
        ram_addr = lat_addr;
        if (cnt == '0) begin
          ram_we    = 1'b1;
          ram_wdata = prog_value(lat_erase, lat_din, ram_q);
          state_nxt = IDLE;
        end
      end
      HOST: begin
        ram_addr  = host_addr;
        ram_we    = host_we;
        ram_wdata = host_din;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= '0;
      lat_addr  <= '0;
      lat_din   <= '0;
      lat_erase <= 1'b0;
      rd_p1     <= 1'b0;
      host_ack  <= 1'b0;
      dout_q    <= '0;
      host_q    <= '0;
      dirty     <= 1'b0;
    end else begin
      if (start_prog) begin
        cnt       <= CW'(PROG_CYCLES - 1);
        lat_addr  <= a;
        lat_din   <= din;
        lat_erase <= (mode == CMD_ERASE);
      end else if (state == PROG && cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
      // RAM output stage: capture the read word so the outputs hold between accesses
      rd_p1    <= rd_go;
      host_ack <= (state == HOST);
      if (rd_p1)    dout_q <= ram_q;
      if (host_ack) host_q <= ram_q;
      if (prog_last)      dirty <= 1'b1;
      else if (dirty_clr) dirty <= 1'b0;
    end
  end

  assign busy      = (state != IDLE);
  assign dout      = rd_p1 ? ram_q : dout_q;
  assign host_dout = host_ack ? ram_q : host_q;

endmodule
